// File: rtl/apb_requester_mc.sv
// APB4 requester: turns valid/ready front-end requests into APB transfers to one of
// NUM_SLV address-decoded completers, with decode-error and wait-state timeout reporting.
module apb_requester_mc #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter int                REGION_BITS = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                TIMEOUT     = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_decerr,
  output logic                      rsp_timeout,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] NUM_SLV_A = ADDR_W'(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx_reg;
  logic [TO_W-1:0]   wait_cnt_reg;

  logic [ADDR_W-1:0]  req_off;
  logic [ADDR_W-1:0]  req_region;
  logic               req_hit;
  logic [IDX_W-1:0]   req_idx;
  logic [NUM_SLV-1:0] req_onehot;

  logic               pready_sel;
  logic               pslverr_sel;
  logic [DATA_W-1:0]  prdata_sel;
  logic               timeout_hit;
  logic               xfer_done;
  logic               accept;

  // Region decode of the address being accepted; it is registered together with the
  // address, so the transfer runs on the captured decode.
  assign req_off    = req_addr - BASE_ADDR;
  assign req_region = req_off >> REGION_BITS;
  assign req_hit    = (req_addr >= BASE_ADDR) && (req_region < NUM_SLV_A);
  assign req_idx    = req_region[IDX_W-1:0];

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_onehot
    assign req_onehot[gi] = (req_idx == IDX_W'(gi));
  end

  assign pready_sel  = PREADY[idx_reg];
  assign pslverr_sel = PSLVERR[idx_reg];
  assign prdata_sel  = PRDATA[idx_reg*DATA_W +: DATA_W];

  // The wait that would bring the counter to TIMEOUT aborts, unless PREADY arrives then.
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !pready_sel &&
                       (wait_cnt_reg == TO_LAST);
  assign xfer_done   = (state == ACCESS) && (pready_sel || timeout_hit);
  assign req_ready   = !PRESET && ((state == IDLE) || xfer_done);
  assign accept      = req_valid && req_ready;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= IDLE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      PADDR        <= '0;
      PWRITE       <= 1'b0;
      PENABLE      <= 1'b0;
      PWDATA       <= '0;
      PSTRB        <= '0;
      PSEL         <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_decerr   <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_decerr  <= 1'b0;
      rsp_timeout <= 1'b0;

      case (state)
        IDLE: ;
        SETUP: begin
          PENABLE      <= 1'b1;
          wait_cnt_reg <= '0;
          state        <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done) begin
            rsp_valid <= 1'b1;
            if (pready_sel) begin
              rsp_err   <= pslverr_sel;
              rsp_rdata <= (!PWRITE && !pslverr_sel) ? prdata_sel : '0;
            end else begin
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
            PENABLE <= 1'b0;
            PSEL    <= '0;
            state   <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        DECERR: begin
          rsp_valid  <= 1'b1;
          rsp_err    <= 1'b1;
          rsp_decerr <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Acceptance overrides the end-of-transfer values above, giving back-to-back SETUP.
      if (accept) begin
        PADDR   <= req_addr;
        PWRITE  <= req_write;
        PWDATA  <= req_wdata;
        PSTRB   <= req_write ? req_strb : '0;
        PENABLE <= 1'b0;
        idx_reg <= req_idx;
        if (req_hit) begin
          PSEL  <= req_onehot;
          state <= SETUP;
        end else begin
          PSEL  <= '0;
          state <= DECERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_requester_mc.sv
// Randomised bench for apb_requester_mc: behavioural completers plus a response scoreboard.
module tb_apb_requester_mc;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic [DW/8-1:0]   req_strb = '0;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rsp_decerr;
  logic              rsp_timeout;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [DW-1:0]     PWDATA;
  logic [DW/8-1:0]   PSTRB;
  logic [NS-1:0]     PSEL;
  logic [NS-1:0]     PREADY = '0;
  logic [NS*DW-1:0]  PRDATA = '0;
  logic [NS-1:0]     PSLVERR = '0;

  apb_requester_mc #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .REGION_BITS(12),
    .BASE_ADDR(BASE), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_decerr(rsp_decerr), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PSEL(PSEL), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        err;
    logic [31:0] data;
  } plan_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        decerr;
    logic        tmo;
    int          cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    n_rsp = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: address map and completion rules in plain arithmetic.
  function automatic logic mapped(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 32'd4096) < NS);
  endfunction

  function automatic int slave_of(input logic [31:0] a);
    return int'((a - BASE) / 32'd4096);
  endfunction

  function automatic exp_t model(input plan_t p, input int acc);
    exp_t e;
    e.addr = p.addr; e.rdata = '0; e.err = 1'b0; e.decerr = 1'b0; e.tmo = 1'b0;
    if (!mapped(p.addr)) begin
      e.err = 1'b1; e.decerr = 1'b1; e.cyc = acc + 2;
    end else if (p.waits >= TO) begin
      e.err = 1'b1; e.tmo = 1'b1; e.cyc = acc + 2 + TO;
    end else begin
      e.err = p.err;
      if (!p.write && !p.err) e.rdata = p.data;
      e.cyc = acc + 3 + p.waits;
    end
    return e;
  endfunction

  // Completer model: follows the plan queued at acceptance; unselected slaves drive noise.
  plan_t cur;
  int    acnt;
  always @(negedge PCLK) begin : slv_blk
    int s;
    logic [3:0] oh;
    #1;
    PREADY  = 4'($urandom);
    PSLVERR = 4'($urandom);
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = $urandom;
    if (!PRESET && PSEL != '0) begin
      if (!PENABLE) begin
        if (plan_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL setup_no_plan: PSEL=%b with no mapped request pending", PSEL);
        end else begin
          cur  = plan_q.pop_front();
          acnt = 0;
        end
      end
      s  = slave_of(cur.addr);
      oh = 4'b0001 << s;
      check(PENABLE ? "access_ctl" : "setup_ctl", {PSEL, PSTRB, PWRITE, PADDR},
            {oh, cur.write ? cur.strb : 4'b0000, cur.write, cur.addr});
      check("pwdata", PWDATA, cur.wdata);
      if (PENABLE) begin
        PREADY[s] = (acnt >= cur.waits);
        if (PREADY[s]) begin
          PSLVERR[s] = cur.err;
          PRDATA[s*DW +: DW] = cur.data;
        end
        acnt++;
      end
    end
  end

  // Scoreboard monitor.
  exp_t me;
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid err=%b rdata=%h, none expected",
                   rsp_err, rsp_rdata);
        end else begin
          me = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, me.rdata);
          check("rsp_flags", {rsp_err, rsp_decerr, rsp_timeout}, {me.err, me.decerr, me.tmo});
          check("rsp_cycle", cyc, me.cyc);
          n_rsp++;
          $display("rsp %0d addr=%h rdata=%h err=%b dec=%b tmo=%b cyc=%0d", n_rsp, me.addr,
                   rsp_rdata, rsp_err, rsp_decerr, rsp_timeout, cyc);
        end
      end else begin
        check("rsp_idle_zero", {rsp_rdata, rsp_err, rsp_decerr, rsp_timeout}, 64'd0);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int waits, input logic err,
                       input logic [31:0] data, input int gap);
    plan_t p;
    int    t;
    p.write = w; p.addr = a; p.wdata = wd; p.strb = st;
    p.waits = waits; p.err = err; p.data = data;
    repeat (gap) @(negedge PCLK);
    @(negedge PCLK); #2;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_strb = st;
    t = 0;
    forever begin
      #2;
      if (req_ready) break;
      t++;
      if (t > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_wait: req_ready stayed %b for %0d cycles", req_ready, t);
        req_valid = 1'b0;
        return;
      end
      @(negedge PCLK); #2;
    end
    if (mapped(a)) plan_q.push_back(p);
    exp_q.push_back(model(p, cyc));
    @(posedge PCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge PCLK);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d responses still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    int          r;
    int          waits;
    #1 PRESET = 1'b1;
    #2;
    check("reset_bus", {PSEL, PENABLE, PWRITE, PSTRB, PADDR}, 64'd0);
    check("reset_data", PWDATA, 64'd0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_decerr, rsp_timeout, rsp_rdata}, 64'd0);
    check("reset_ready", req_ready, 64'd0);
    @(negedge PCLK); #3 PRESET = 1'b0;

    // Directed cases.
    issue(0, 32'h1000_1004, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 0);
    issue(1, 32'h1000_3010, 32'h1234_5678, 4'b0101, 3, 0, 32'h0, 0);
    issue(0, 32'h1000_2000, 32'h0, 4'hF, 1, 1, 32'h5555_AAAA, 0);
    issue(0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    issue(0, 32'h1000_0000, 32'h0, 4'hF, 1000, 0, 32'h0, 0);
    issue(0, 32'h1000_0008, 32'h0, 4'hF, 0, 0, 32'h0BAD_BEEF, 0);
    issue(0, 32'h1000_1000, 32'h0, 4'hF, TO - 1, 0, 32'h1357_9BDF, 0);
    issue(1, 32'h1000_2004, 32'hFFFF_0000, 4'b1100, TO, 0, 32'h0, 0);
    issue(0, 32'h0FFF_FFFC, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    issue(0, 32'h1000_4000, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    drain();
    issue(0, 32'h1000_0100, 32'h0, 4'hF, 0, 0, 32'hA0A0_0000, 0);
    issue(0, 32'h1000_1100, 32'h0, 4'hF, 0, 0, 32'hA1A1_1111, 0);
    issue(0, 32'h1000_2100, 32'h0, 4'hF, 0, 0, 32'hA2A2_2222, 0);
    drain();

    // Randomised traffic.
    for (int k = 0; k < 160; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h2000_0000 + ($urandom & 32'h000F_FFFC);
          1:       a = BASE - 32'd4 * $urandom_range(1, 1000);
          default: a = BASE + 32'h4000 + 32'd4 * $urandom_range(0, 1023);
        endcase
      end else begin
        a = BASE + 32'h1000 * $urandom_range(0, 3) + 32'd4 * $urandom_range(0, 1023);
      end
      r = int'($urandom_range(0, 19));
      waits = (r < 15) ? (r % 4) : (r - 1);
      issue(1'($urandom), a, $urandom, 4'($urandom), waits, ($urandom_range(0, 7) == 0),
            $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    drain();

    // Reset in the middle of ACCESS drops the transfer silently.
    issue(0, 32'h1000_3000, 32'h0, 4'hF, 1000, 0, 32'h0, 0);
    repeat (4) @(negedge PCLK);
    #3 PRESET = 1'b1;
    #1;
    check("midreset_bus", {PSEL, PENABLE}, 64'd0);
    check("midreset_rsp", {rsp_valid, req_ready}, 64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (2) @(negedge PCLK);
    #3 PRESET = 1'b0;
    issue(0, 32'h1000_3008, 32'h0, 4'hF, 2, 0, 32'h7777_8888, 0);
    issue(1, 32'h1000_0010, 32'h0102_0304, 4'b0011, 0, 0, 32'h0, 0);
    drain();
    repeat (30) @(negedge PCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
